// File: rtl/pkg_write_controller_pkg.sv
// Shared definitions for the packet-buffer write side.
//
// Holds the write-controller state encoding and the default widths used by
// the controller, the table manager and the address manager.
//
// Optional feature macro used elsewhere in this slice: PKG_WRITE_STAT_EN.
package pkg_write_controller_pkg;

  localparam int DEF_ADDR_PAGE_NUM_LOG = 4;
  localparam int DEF_PAGE_WORD_LOG     = 2;
  localparam int DEF_DATA_WIDTH        = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    COMMIT = 2'd2,
    FETCH  = 2'd3
  } state_e;

endpackage

// File: rtl/pkg_write_controller_if.sv
// Bus bundle between the write controller and its neighbours.
//
// Groups the upstream word stream, the free-address table pop port, the data
// table push port, the packet RAM write port and the packet-done pulse.
//   master : the write controller (drives in_ready, table pulses, RAM port,
//            pkg_done)
//   slave  : the environment (drives the word stream and free-table head)
//
// Stream handshake: a word (in_data, in_last) transfers on a rising clock
// edge where in_valid and in_ready are both high; in_valid may drop at any
// time and in_ready only rises while the controller owns a page.
interface pkg_write_controller_if
  import pkg_write_controller_pkg::*;
#(
  parameter int ADDR_PAGE_NUM_LOG = DEF_ADDR_PAGE_NUM_LOG,
  parameter int PAGE_WORD_LOG     = DEF_PAGE_WORD_LOG,
  parameter int ADDR_WIDTH        = ADDR_PAGE_NUM_LOG + PAGE_WORD_LOG,
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH
);

  logic                         in_valid;
  logic [DATA_WIDTH-1:0]        in_data;
  logic                         in_last;
  logic                         in_ready;
  logic                         free_table_empty;
  logic [ADDR_PAGE_NUM_LOG-1:0] free_table_read_addr;
  logic                         free_table_read_req;
  logic                         data_table_write_req;
  logic [ADDR_PAGE_NUM_LOG-1:0] data_table_write_addr;
  logic                         ram_write_en;
  logic [ADDR_WIDTH-1:0]        ram_write_addr;
  logic [DATA_WIDTH-1:0]        ram_write_data;
  logic                         pkg_done;

  modport master (
    input  in_valid, in_data, in_last, free_table_empty, free_table_read_addr,
    output in_ready, free_table_read_req, data_table_write_req,
           data_table_write_addr, ram_write_en, ram_write_addr,
           ram_write_data, pkg_done
  );

  modport slave (
    output in_valid, in_data, in_last, free_table_empty, free_table_read_addr,
    input  in_ready, free_table_read_req, data_table_write_req,
           data_table_write_addr, ram_write_en, ram_write_addr,
           ram_write_data, pkg_done
  );

endinterface

// File: rtl/pkg_write_stat.sv
// Packet and page statistics counters for the write controller.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   pkg_done_i        : one pulse per completed packet
//   page_commit_i     : one pulse per page pushed to the data table
//   stat_pkg_cnt_o    : completed packets, wraps 16'hFFFF -> 0
//   stat_page_cnt_o   : committed pages, wraps 16'hFFFF -> 0
//
// Only instantiated when PKG_WRITE_STAT_EN is defined.
module pkg_write_stat (
  input  logic        clk,
  input  logic        rst,
  input  logic        pkg_done_i,
  input  logic        page_commit_i,
  output logic [15:0] stat_pkg_cnt_o,
  output logic [15:0] stat_page_cnt_o
);

  logic [15:0] pkg_cnt_q, pkg_cnt_d;
  logic [15:0] page_cnt_q, page_cnt_d;

  // Natural 16-bit overflow gives the wrap to zero.
  always_comb begin
    pkg_cnt_d  = pkg_cnt_q;
    page_cnt_d = page_cnt_q;
    if (pkg_done_i)    pkg_cnt_d  = pkg_cnt_q + 16'd1;
    if (page_commit_i) page_cnt_d = page_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkg_cnt_q  <= '0;
      page_cnt_q <= '0;
    end else begin
      pkg_cnt_q  <= pkg_cnt_d;
      page_cnt_q <= page_cnt_d;
    end
  end

  assign stat_pkg_cnt_o  = pkg_cnt_q;
  assign stat_page_cnt_o = page_cnt_q;

endmodule

// File: rtl/pkg_write_controller.sv
// Upstream write-side controller for the linked-list packet buffer.
//
// Pops a free page, streams packet words into RAM at {page, offset} with
// zero-cycle latency, and pushes each filled (or packet-final) page into the
// data table. A packet spanning several pages costs two bubble cycles per
// page boundary (COMMIT, FETCH).
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   bus (master)    : word stream, free/data table ports, RAM port, pkg_done
//   state_o         : current FSM state, for observation
//   stat_pkg_cnt,
//   stat_page_cnt   : statistics, present only with PKG_WRITE_STAT_EN
//
// Configuration macro: PKG_WRITE_STAT_EN adds the statistics counters.
module pkg_write_controller
  import pkg_write_controller_pkg::*;
#(
  parameter int ADDR_PAGE_NUM_LOG = DEF_ADDR_PAGE_NUM_LOG,
  parameter int PAGE_WORD_LOG     = DEF_PAGE_WORD_LOG,
  parameter int ADDR_WIDTH        = ADDR_PAGE_NUM_LOG + PAGE_WORD_LOG,
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  pkg_write_controller_if.master bus,
`ifdef PKG_WRITE_STAT_EN
  output logic [15:0]           stat_pkg_cnt,
  output logic [15:0]           stat_page_cnt,
`endif
  output state_e                state_o
);

  localparam logic [PAGE_WORD_LOG-1:0] OFFSET_MAX = {PAGE_WORD_LOG{1'b1}};

  state_e                       state_q, state_d;
  logic [ADDR_PAGE_NUM_LOG-1:0] page_q, page_d;
  logic [PAGE_WORD_LOG-1:0]     offset_q, offset_d;
  logic                         last_q, last_d;
  logic                         pkg_done_q;

  logic                         in_ready;
  logic                         free_req;
  logic                         dt_req;
  logic                         ram_we;
  logic [ADDR_WIDTH-1:0]        ram_addr;

  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    offset_d = offset_q;
    last_d   = last_q;
    in_ready = 1'b0;
    free_req = 1'b0;
    dt_req   = 1'b0;
    ram_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A page is only claimed once a packet is actually offered.
        if (bus.in_valid && !bus.free_table_empty) begin
          free_req = 1'b1;
          page_d   = bus.free_table_read_addr;
          offset_d = '0;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          ram_we   = 1'b1;
          offset_d = offset_q + PAGE_WORD_LOG'(1);
          // Last word landing on the final offset is a single packet-end commit.
          if (bus.in_last || offset_q == OFFSET_MAX) begin
            last_d  = bus.in_last;
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        dt_req  = 1'b1;
        state_d = last_q ? IDLE : FETCH;
      end
      FETCH: begin
        // Continuation page is fetched without waiting for in_valid.
        if (!bus.free_table_empty) begin
          free_req = 1'b1;
          page_d   = bus.free_table_read_addr;
          offset_d = '0;
          state_d  = WRITE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      page_q     <= '0;
      offset_q   <= '0;
      last_q     <= 1'b0;
      pkg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      offset_q   <= offset_d;
      last_q     <= last_d;
      pkg_done_q <= (state_q == COMMIT) && last_q;
    end
  end

  assign ram_addr = {page_q, offset_q};

  // The IDLE pop is combinational from in_valid, so it is masked during reset
  // to keep every output low while rst is held.
  assign bus.in_ready              = in_ready;
  assign bus.free_table_read_req   = free_req && !rst;
  assign bus.data_table_write_req  = dt_req;
  assign bus.data_table_write_addr = page_q;
  assign bus.ram_write_en          = ram_we;
  assign bus.ram_write_addr        = ram_addr;
  assign bus.ram_write_data        = ram_we ? bus.in_data : '0;
  assign bus.pkg_done              = pkg_done_q;
  assign state_o                   = state_q;

`ifdef PKG_WRITE_STAT_EN
  pkg_write_stat u_stat (
    .clk             (clk),
    .rst             (rst),
    .pkg_done_i      (pkg_done_q),
    .page_commit_i   (dt_req),
    .stat_pkg_cnt_o  (stat_pkg_cnt),
    .stat_page_cnt_o (stat_page_cnt)
  );
`endif

endmodule

// File: tb/tb_pkg_write_controller.sv
module tb_pkg_write_controller;
  import pkg_write_controller_pkg::*;

  logic   clk;
  logic   rst;
  state_e st;
  int     assert_cnt;
  int     fail_cnt;
`ifdef PKG_WRITE_STAT_EN
  logic [15:0] stat_pkg_cnt;
  logic [15:0] stat_page_cnt;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pkg_write_controller_if #(
    .ADDR_PAGE_NUM_LOG (4),
    .PAGE_WORD_LOG     (2),
    .ADDR_WIDTH        (6),
    .DATA_WIDTH        (8)
  ) bus ();

  pkg_write_controller #(
    .ADDR_PAGE_NUM_LOG (4),
    .PAGE_WORD_LOG     (2),
    .ADDR_WIDTH        (6),
    .DATA_WIDTH        (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
`ifdef PKG_WRITE_STAT_EN
    .stat_pkg_cnt  (stat_pkg_cnt),
    .stat_page_cnt (stat_page_cnt),
`endif
    .state_o       (st)
  );

  // checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l,
                       input logic e, input logic [3:0] fa);
    bus.in_valid             = v;
    bus.in_data              = d;
    bus.in_last              = l;
    bus.free_table_empty     = e;
    bus.free_table_read_addr = fa;
  endtask

  // IDLE or FETCH cycle that should pop a page
  task automatic pop(input string tag, input logic [3:0] fa, input state_e exp_st);
    bus.in_valid = 1'b1;
    bus.free_table_empty = 1'b0;
    bus.free_table_read_addr = fa;
    #1;
    chk({tag, "_st"},   32'(st), 32'(exp_st));
    chk({tag, "_frq"},  32'(bus.free_table_read_req), 32'd1);
    chk({tag, "_rdy"},  32'(bus.in_ready), 32'd0);
    chk({tag, "_we"},   32'(bus.ram_write_en), 32'd0);
    chk({tag, "_dtrq"}, 32'(bus.data_table_write_req), 32'd0);
    tick();
  endtask

  task automatic word(input string tag, input logic [7:0] d, input logic l, input int exp_addr);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    #1;
    chk({tag, "_rdy"},   32'(bus.in_ready), 32'd1);
    chk({tag, "_we"},    32'(bus.ram_write_en), 32'd1);
    chk({tag, "_waddr"}, 32'(bus.ram_write_addr), 32'(exp_addr));
    chk({tag, "_wdata"}, 32'(bus.ram_write_data), 32'(d));
    chk({tag, "_frq"},   32'(bus.free_table_read_req), 32'd0);
    tick();
  endtask

  task automatic commit(input string tag, input logic [3:0] page);
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b0;
    #1;
    chk({tag, "_st"},    32'(st), 32'(COMMIT));
    chk({tag, "_dtrq"},  32'(bus.data_table_write_req), 32'd1);
    chk({tag, "_dtad"},  32'(bus.data_table_write_addr), 32'(page));
    chk({tag, "_rdy"},   32'(bus.in_ready), 32'd0);
    chk({tag, "_we"},    32'(bus.ram_write_en), 32'd0);
    chk({tag, "_frq"},   32'(bus.free_table_read_req), 32'd0);
    chk({tag, "_done"},  32'(bus.pkg_done), 32'd0);
    bus.in_valid = 1'b0;
    tick();
  endtask

  // cycle after a packet-final commit: back in IDLE with the done pulse
  task automatic done_chk(input string tag);
    bus.in_valid = 1'b0;
    #1;
    chk({tag, "_st"},   32'(st), 32'(IDLE));
    chk({tag, "_done"}, 32'(bus.pkg_done), 32'd1);
    chk({tag, "_dtrq"}, 32'(bus.data_table_write_req), 32'd0);
    tick();
    chk({tag, "_done_clr"}, 32'(bus.pkg_done), 32'd0);
  endtask

  initial begin
    assert_cnt = 0;
    fail_cnt   = 0;
    rst        = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b1, 4'd0);
    tick();
    tick();
    chk("rst_st",   32'(st), 32'(IDLE));
    chk("rst_rdy",  32'(bus.in_ready), 32'd0);
    chk("rst_we",   32'(bus.ram_write_en), 32'd0);
    chk("rst_dtrq", 32'(bus.data_table_write_req), 32'd0);
    chk("rst_done", 32'(bus.pkg_done), 32'd0);
    rst = 1'b0;
    tick();

    // IDLE holds while the free table is empty
    drive(1'b1, 8'hA1, 1'b0, 1'b1, 4'd5);
    #1;
    chk("idle_empty_frq", 32'(bus.free_table_read_req), 32'd0);
    tick();
    chk("idle_empty_st", 32'(st), 32'(IDLE));

    // 1: 3-word packet into page 5
    pop("t1_pop", 4'd5, IDLE);
    word("t1_w0", 8'hA1, 1'b0, 20);
    word("t1_w1", 8'hA2, 1'b0, 21);
    word("t1_w2", 8'hA3, 1'b1, 22);
    commit("t1_cm", 4'd5);
    done_chk("t1_end");

    // 2: 6-word packet over pages 2 and 9
    pop("t2_pop0", 4'd2, IDLE);
    word("t2_w0", 8'h10, 1'b0, 8);
    word("t2_w1", 8'h11, 1'b0, 9);
    word("t2_w2", 8'h12, 1'b0, 10);
    word("t2_w3", 8'h13, 1'b0, 11);
    commit("t2_cm0", 4'd2);
    bus.in_valid = 1'b0;
    #1;
    chk("t2_fetch_done", 32'(bus.pkg_done), 32'd0);
    pop("t2_pop1", 4'd9, FETCH);
    word("t2_w4", 8'h14, 1'b0, 36);
    word("t2_w5", 8'h15, 1'b1, 37);
    commit("t2_cm1", 4'd9);
    done_chk("t2_end");
`ifdef PKG_WRITE_STAT_EN
    chk("stat_pkg",  32'(stat_pkg_cnt), 32'd2);
    chk("stat_page", 32'(stat_page_cnt), 32'd3);
`endif

    // 3: exactly one page, last on offset 3 -> single commit, no FETCH
    pop("t3_pop", 4'd3, IDLE);
    word("t3_w0", 8'h30, 1'b0, 12);
    word("t3_w1", 8'h31, 1'b0, 13);
    // in_valid gap mid-page: WRITE waits, nothing written
    bus.in_valid = 1'b0;
    #1;
    chk("t3_gap_we",  32'(bus.ram_write_en), 32'd0);
    chk("t3_gap_rdy", 32'(bus.in_ready), 32'd1);
    tick();
    word("t3_w2", 8'h32, 1'b0, 14);
    word("t3_w3", 8'h33, 1'b1, 15);
    commit("t3_cm", 4'd3);
    done_chk("t3_end");

    // 4: FETCH stalls 10 cycles on an empty free table
    pop("t4_pop0", 4'd1, IDLE);
    word("t4_w0", 8'h40, 1'b0, 4);
    word("t4_w1", 8'h41, 1'b0, 5);
    word("t4_w2", 8'h42, 1'b0, 6);
    word("t4_w3", 8'h43, 1'b0, 7);
    commit("t4_cm0", 4'd1);
    drive(1'b1, 8'h44, 1'b0, 1'b1, 4'd6);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("t4_stall%0d_st", i),  32'(st), 32'(FETCH));
      chk($sformatf("t4_stall%0d_rdy", i), 32'(bus.in_ready), 32'd0);
      chk($sformatf("t4_stall%0d_we", i),  32'(bus.ram_write_en), 32'd0);
      chk($sformatf("t4_stall%0d_frq", i), 32'(bus.free_table_read_req), 32'd0);
      tick();
    end
    pop("t4_pop1", 4'd6, FETCH);
    word("t4_w4", 8'h44, 1'b1, 24);
    commit("t4_cm1", 4'd6);
    done_chk("t4_end");

    // 5: reset mid-WRITE after two words
    pop("t5_pop", 4'd4, IDLE);
    word("t5_w0", 8'h50, 1'b0, 16);
    word("t5_w1", 8'h51, 1'b0, 17);
    drive(1'b1, 8'h52, 1'b0, 1'b0, 4'd7);
    rst = 1'b1;
    #1;
    chk("t5_rst_st",   32'(st), 32'(IDLE));
    chk("t5_rst_rdy",  32'(bus.in_ready), 32'd0);
    chk("t5_rst_we",   32'(bus.ram_write_en), 32'd0);
    chk("t5_rst_wad",  32'(bus.ram_write_addr), 32'd0);
    chk("t5_rst_wd",   32'(bus.ram_write_data), 32'd0);
    chk("t5_rst_frq",  32'(bus.free_table_read_req), 32'd0);
    chk("t5_rst_dtrq", 32'(bus.data_table_write_req), 32'd0);
    chk("t5_rst_dtad", 32'(bus.data_table_write_addr), 32'd0);
    chk("t5_rst_done", 32'(bus.pkg_done), 32'd0);
    tick();
    chk("t5_rst_hold_dtrq", 32'(bus.data_table_write_req), 32'd0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("t5_post_dtrq", 32'(bus.data_table_write_req), 32'd0);
`ifdef PKG_WRITE_STAT_EN
    chk("t5_stat_pkg",  32'(stat_pkg_cnt), 32'd0);
    chk("t5_stat_page", 32'(stat_page_cnt), 32'd0);
`endif
    pop("t5_pop2", 4'd7, IDLE);
    word("t5_w2", 8'h5A, 1'b1, 28);
    commit("t5_cm", 4'd7);
    done_chk("t5_end");
`ifdef PKG_WRITE_STAT_EN
    chk("t5_stat_pkg1",  32'(stat_pkg_cnt), 32'd1);
    chk("t5_stat_page1", 32'(stat_page_cnt), 32'd1);
`endif

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/pkg_write_controller.md
Name: pkg_write_controller

Overview:
- Upstream write-side controller for the linked-list packet buffer.
- Accepts a word stream with a packet-last marker and pops a free page from the free-address table manager.
- Writes each word into packet RAM at {page, offset}.
- On each page close, pushes the page address into the data table manager via data_table_write_req / data_table_write_addr.

Parameters:
ADDR_PAGE_NUM_LOG, 4, log2 of page count; width of page addresses.
PAGE_WORD_LOG, 2, log2 of words per page.
ADDR_WIDTH, 6, RAM word address width; must equal ADDR_PAGE_NUM_LOG + PAGE_WORD_LOG.
DATA_WIDTH, 8, data word width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active high.
in_valid  in  1  input word valid.
in_data  in  DATA_WIDTH  input word.
in_last  in  1  word is last of packet.
in_ready  out  1  word accepted when in_valid & in_ready.
free_table_empty  in  1  no free page available.
free_table_read_addr  in  ADDR_PAGE_NUM_LOG  head free page; valid while !free_table_empty.
free_table_read_req  out  1  pop head free page (1-cycle pulse).
data_table_write_req  out  1  push page into data table (1-cycle pulse).
data_table_write_addr  out  ADDR_PAGE_NUM_LOG  page being pushed.
ram_write_en  out  1  RAM write strobe.
ram_write_addr  out  ADDR_WIDTH  {page, offset}.
ram_write_data  out  DATA_WIDTH  RAM write data.
pkg_done  out  1  1-cycle pulse after the last page of a packet is committed.

Behaviour:
- Reset: state IDLE; all outputs 0; page and offset registers 0. Reset mid-packet abandons the packet; no partial commit is issued.
- State IDLE:
  - in_ready=0.
  - If in_valid & !free_table_empty: free_table_read_req=1 (combinational, same cycle), latch free_table_read_addr into page_reg, offset<=0, go WRITE.
  - If free_table_empty: stay IDLE.
- State WRITE:
  - in_ready=1.
  - On handshake: ram_write_en=1, ram_write_addr={page_reg, offset}, ram_write_data=in_data, all combinational from the current word. Zero-cycle latency input to RAM.
  - After a handshake, offset increments, wrapping modulo 2^PAGE_WORD_LOG.
  - Go COMMIT if in_last was set or offset == 2^PAGE_WORD_LOG-1; latch last_flag=in_last.
  - If both conditions hold on the same word: one commit only, treated as packet end.
- State COMMIT:
  - in_ready=0; data_table_write_req=1; data_table_write_addr=page_reg (registered, stable this cycle).
  - If last_flag: pkg_done=1 next cycle, go IDLE.
  - Else go FETCH.
- State FETCH:
  - in_ready=0.
  - If !free_table_empty: free_table_read_req=1, latch page, offset<=0, go WRITE.
  - Else stall in FETCH indefinitely; input is back-pressured.
- Handshake rules:
  - in_data and in_last are sampled only when in_valid & in_ready.
  - in_valid may drop mid-packet; WRITE simply waits.
- Table pulse rules:
  - free_table_read_req and data_table_write_req never assert in the same cycle.
  - Each is at most 1 cycle per page.
- Throughput: one word per cycle within a page, plus 2 bubble cycles (COMMIT, FETCH) per page boundary.
- A short packet occupies a whole page; unused words are not written.

Optional Feature:
- Macro PKG_WRITE_STAT_EN.
- Defined:
  - Adds outputs stat_pkg_cnt[15:0] and stat_page_cnt[15:0], both 0 on reset.
  - stat_pkg_cnt increments on pkg_done; stat_page_cnt increments on data_table_write_req.
  - Both wrap at 16'hFFFF -> 0.
- Not defined: ports and counters are absent; no other behaviour changes.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, WRITE=2'd1, COMMIT=2'd2, FETCH=2'd3;
  - default widths (ADDR_PAGE_NUM_LOG, PAGE_WORD_LOG, DATA_WIDTH), shared with the table manager and addr_manager.
- Single module; the optional stat counter may be a small sub-module, pkg_write_stat, instantiated under the macro.

Test Plan:
1. Reset, then 3-word packet (0xA1, 0xA2, 0xA3 with last), free head=5 -> RAM writes at 20, 21, 22; one data_table_write_req with addr 5; pkg_done 1 cycle later.
2. 6-word packet, free pages 2 then 9 -> words 0-3 at addrs 8-11, commit page 2; FETCH pops 9; words 4-5 at 36-37; commit 9; single pkg_done.
3. Exactly 4-word packet (last on offset 3) -> exactly one commit; no FETCH; back to IDLE.
4. free_table_empty=1 during FETCH for 10 cycles -> in_ready=0 and no RAM writes; resumes on the cycle empty drops.
5. rst asserted mid-WRITE after 2 words -> all outputs 0 immediately; no data_table_write_req; next packet starts cleanly.
6. With PKG_WRITE_STAT_EN: run tests 1 and 2 -> stat_pkg_cnt=2, stat_page_cnt=3.
